// File: rtl/seq_pkg.sv
// Shared sequencer definitions: state encodings and default widths, also used
// by the downstream state definer.
package seq_pkg;
  localparam int SEQ_STATE_W    = 4;
  localparam int SEQ_NUM_STATES = 10;
  localparam int SEQ_CNT_W      = 26;  // holds 60,000,000
  localparam int SEQ_CYC_W      = 16;

  typedef enum logic [SEQ_STATE_W-1:0] {
    Q0 = 4'd0, Q1 = 4'd1, Q2 = 4'd2, Q3 = 4'd3, Q4 = 4'd4,
    Q5 = 4'd5, Q6 = 4'd6, Q7 = 4'd7, Q8 = 4'd8, Q9 = 4'd9
  } seq_state_e;
endpackage

// File: rtl/seq_dwell_timer_if.sv
// Sequencer loop bus: the state definer (master) closes the loop through the
// dwell timer (slave).
interface seq_dwell_timer_if
  import seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W,
  parameter int CYC_W = SEQ_CYC_W
);
  logic                   run;
  logic [SEQ_STATE_W-1:0] next_state;
  logic [SEQ_STATE_W-1:0] state;
  logic [CNT_W-1:0]       n_clks;
  logic                   state_entry;
  logic                   cycle_done;
  logic [CYC_W-1:0]       cycle_cnt;
  logic                   illegal_err;
  logic                   wdog_fault;

  modport master (output run, next_state,
                  input  state, n_clks, state_entry, cycle_done, cycle_cnt,
                         illegal_err, wdog_fault);
  modport slave  (input  run, next_state,
                  output state, n_clks, state_entry, cycle_done, cycle_cnt,
                         illegal_err, wdog_fault);
endinterface

// File: rtl/seq_dwell_counter.sv
// Dwell counter: synchronous clear, enable, saturating increment and a
// terminal-count flag at all-ones.
module seq_dwell_counter #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  assign tc = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seq_dwell_timer.sv
// Sequence state register with dwell timing, entry/cycle pulses and sticky
// error flags. Define SEQ_WATCHDOG_EN to force Q0 when the dwell counter tops out.
module seq_dwell_timer
  import seq_pkg::*;
#(
  parameter int NUM_STATES = SEQ_NUM_STATES,
  parameter int CNT_W      = SEQ_CNT_W,
  parameter int CYC_W      = SEQ_CYC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_dwell_timer_if.slave  bus
);
  seq_state_e       state_q, state_d;
  logic             run_q, entry_q, entry_d, done_q, done_d;
  logic             err_q, wdog_q, wdog_trip, illegal, tc, clr;
  logic [CYC_W-1:0] cyc_q;
  logic [CNT_W-1:0] n_clks;

  assign illegal = (int'(bus.next_state) >= NUM_STATES);

`ifdef SEQ_WATCHDOG_EN
  assign wdog_trip = bus.run && run_q && tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wdog_q <= 1'b0;
    else if (wdog_trip) wdog_q <= 1'b1;
  end
`else
  logic unused_tc;
  assign unused_tc = tc;
  assign wdog_trip = 1'b0;
  assign wdog_q    = 1'b0;
`endif

  // Only a settled, legal, non-watchdog request reaches the state register;
  // the first run cycle is always a fresh Q0 entry.
  always_comb begin
    state_d = Q0;
    done_d  = 1'b0;
    if (bus.run && run_q && !illegal && !wdog_trip) begin
      state_d = seq_state_e'(bus.next_state);
      done_d  = (state_q == Q9) && (state_d == Q0);
    end
    entry_d = bus.run && (!run_q || (state_d != state_q));
    clr     = !bus.run || !run_q || illegal || wdog_trip || (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Q0;
      run_q   <= 1'b0;
      entry_q <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= bus.run;
      entry_q <= entry_d;
      done_q  <= done_d;
      if (done_d)              cyc_q <= cyc_q + 1'b1;
      if (bus.run && illegal)  err_q <= 1'b1;
    end
  end

  seq_dwell_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (bus.run),
    .cnt   (n_clks),
    .tc    (tc)
  );

  assign bus.state       = state_q;
  assign bus.n_clks      = n_clks;
  assign bus.state_entry = entry_q;
  assign bus.cycle_done  = done_q;
  assign bus.cycle_cnt   = cyc_q;
  assign bus.illegal_err = err_q;
  assign bus.wdog_fault  = wdog_q;
endmodule

// File: doc/seq_dwell_timer.md
SEQ_DWELL_TIMER -- requirements
Module: seq_dwell_timer

Interface
REQ-001 Parameter: NUM_STATES, 10, number of legal sequence states Q0..Q9 (encodings 0..NUM_STATES-1).
REQ-002 Parameter: CNT_W, 26, dwell counter width; must hold 60,000,000.
REQ-003 Parameter: CYC_W, 16, completed-cycle counter width.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  level enable; 1 = sequence advancing, 0 = park in Q0.
REQ-007 next_state  in  4  state requested by the downstream state definer.
REQ-008 state  out  4  current registered sequence state.
REQ-009 n_clks  out  CNT_W  clocks elapsed in current state.
REQ-010 state_entry  out  1  one-cycle pulse on the first cycle in a new state.
REQ-011 cycle_done  out  1  one-cycle pulse when Q9 -> Q0 is taken.
REQ-012 cycle_cnt  out  CYC_W  number of completed Q9 -> Q0 cycles.
REQ-013 illegal_err  out  1  sticky flag: next_state >= NUM_STATES was sampled while run=1.
REQ-014 wdog_fault  out  1  sticky watchdog flag (see Configuration).

Function
REQ-015 The block SHALL register state and n_clks; the state definer computes next_state from them, closing the sequencer loop.
REQ-016 With run=0 at an edge, state SHALL become Q0, n_clks SHALL become 0, and state_entry and cycle_done SHALL be 0.
REQ-017 With run=1 and next_state == state, state SHALL hold and n_clks SHALL increment by 1, saturating at 2^CNT_W-1 without wrapping.
REQ-018 With run=1, next_state != state and next_state legal, state SHALL load next_state, n_clks SHALL load 0 and state_entry SHALL be 1 for exactly that following cycle.
REQ-019 A run 0 -> 1 transition SHALL pulse state_entry in the first run=1 cycle (Q0 entry); n_clks SHALL start counting from 0.
REQ-020 With run=1 and next_state >= NUM_STATES, state SHALL load Q0, n_clks SHALL load 0, illegal_err SHALL set and stay set until reset.
REQ-021 The Q9 -> Q0 transition SHALL pulse cycle_done one cycle and increment cycle_cnt modulo 2^CYC_W; the illegal-state jump to Q0 SHALL NOT count.
REQ-022 Latency: next_state sampled at edge k appears on state after edge k; n_clks and pulses are valid in the same cycle as state.
REQ-023 run=0 SHALL take priority over next_state and over illegal detection; illegal_err SHALL NOT set while run=0.
REQ-024 cycle_cnt SHALL hold its value across run=0 periods; only reset clears it.

Reset
REQ-025 On rst_n=0, asynchronously: state=Q0, n_clks=0, state_entry=0, cycle_done=0, cycle_cnt=0, illegal_err=0, wdog_fault=0.
REQ-026 Deassertion SHALL be synchronous to clk; the first post-reset cycle with run=1 behaves per REQ-019.
REQ-027 Reset asserted mid-state SHALL abandon the dwell with no cycle_done pulse.

Configuration
REQ-028 Macro SEQ_WATCHDOG_EN: when defined, n_clks reaching 2^CNT_W-1 while run=1 SHALL set wdog_fault (sticky until reset) and force state to Q0 with n_clks=0 on the next edge, with no cycle_done.
REQ-029 When SEQ_WATCHDOG_EN is undefined, wdog_fault SHALL be tied 0 and n_clks SHALL saturate per REQ-017; the port list is identical in both builds.

Structure
REQ-030 A shared package seq_pkg SHALL hold the state encodings Q0..Q9, state width (4), NUM_STATES and the default CNT_W; the state definer uses the same package.
REQ-031 One sub-module seq_dwell_counter (synchronous clear, enable, saturating increment, terminal-count flag) SHALL implement n_clks; the state register, pulses, cycle counter and flags live in the top.

Verification
REQ-032 Reset, run=1, next_state=Q0 held 5 cycles -> state=Q0, n_clks=0,1,2,3,4, state_entry=1 only in first cycle.
REQ-033 In Q2 with n_clks=37, drive next_state=Q3 one cycle -> next cycle state=Q3, n_clks=0, state_entry=1, then n_clks=1.
REQ-034 From Q9 drive next_state=Q0 three times across full sequences -> cycle_done pulses 3 times, cycle_cnt=3; cycle_cnt with CYC_W=2 after 5 cycles = 1.
REQ-035 run=1, next_state=4'hC -> state=Q0, n_clks=0, illegal_err=1 and stays 1; same stimulus with run=0 -> illegal_err stays 0.
REQ-036 CNT_W=4, next_state held at Q5: without SEQ_WATCHDOG_EN n_clks stops at 15, wdog_fault=0; with it, after 15 wdog_fault=1 and state=Q0, n_clks=0.
REQ-037 rst_n pulsed low mid-Q4 with n_clks=1000 -> all outputs zero immediately, no cycle_done, Q0 entry pulse on first run=1 cycle after release.
